// File: rtl/qoa_arith_pkg.sv
// qoa_arith_pkg
// Shared definitions for the sequential arithmetic units (divider and
// multiplier): the common handshake state enum, the default operand widths
// and the 32-bit signed saturation constants.
package qoa_arith_pkg;

  // Handshake states shared by the sequential arithmetic units.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } div_state_t;

  // Default widths: 32-bit dividend/quotient, 16-bit divisor/remainder.
  localparam int DIVIDEND_WIDTH = 32;
  localparam int DIVISOR_WIDTH  = 16;

  // Signed 32-bit saturation limits.
  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/sequential_divider.sv
// sequential_divider
// Signed DIVIDEND_W / DIVISOR_W divider using restoring shift-subtract,
// one quotient bit per clock. Operands are captured at start, so the
// inputs may change while a division is in flight.
//
// Ports:
//   sys_clk    single clock, rising edge
//   sys_rst    asynchronous active-high reset
//   start      request a division (sampled only in IDLE)
//   dividend   signed dividend
//   divisor    signed divisor
//   quotient   signed quotient, truncated toward zero
//   remainder  signed remainder, sign follows the dividend
//   finished   one-cycle pulse when quotient/remainder are updated
//   busy       high in every state except IDLE
//   div_zero   last result had a zero divisor
//   overflow   last result was most-negative / -1
module sequential_divider
  import qoa_arith_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_WIDTH,
  parameter int DIVISOR_W  = DIVISOR_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  finished,
  output logic                  busy,
  output logic                  div_zero,
  output logic                  overflow
);

  localparam int                    CNT_W     = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(DIVIDEND_W - 1);
  // Saturation limits scaled down from the 32-bit package constants.
  localparam logic [DIVIDEND_W-1:0] QUOT_MAX  = DIVIDEND_W'(SAT_POS >> (32 - DIVIDEND_W));
  localparam logic [DIVIDEND_W-1:0] QUOT_MIN  = DIVIDEND_W'(SAT_NEG >> (32 - DIVIDEND_W));

  div_state_t state;
  div_state_t next_state;

  // work holds the dividend magnitude; as its MSBs shift into the partial
  // remainder, quotient bits shift in at the bottom, so after the last
  // iteration it holds the quotient magnitude.
  logic [DIVIDEND_W-1:0] work;
  logic [DIVISOR_W-1:0]  divisor_mag;
  logic [DIVISOR_W:0]    partial;
  logic [CNT_W-1:0]      count;
  logic                  dividend_neg;
  logic                  divisor_neg;
  logic                  zero_case;
  logic                  ovf_case;

  logic [DIVIDEND_W-1:0] dividend_mag_in;
  logic [DIVISOR_W-1:0]  divisor_mag_in;
  logic [DIVISOR_W+1:0]  trial;
  logic                  borrow;

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and busy flag.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) next_state = DIVIDE;
      DIVIDE:  if (count == LAST_ITER) next_state = FIXUP;
      FIXUP:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand magnitudes and the trial subtraction. The partial remainder is
  // always below |divisor|, so its top bit stays zero; the trial is one bit
  // wider than the shifted partial so its MSB acts as the borrow.
  always_comb begin
    dividend_mag_in = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    divisor_mag_in  = divisor[DIVISOR_W-1]   ? -divisor  : divisor;
    trial           = {partial, work[DIVIDEND_W-1]} - {2'b00, divisor_mag};
    borrow          = trial[DIVISOR_W+1];
  end

  // Datapath and registered results.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      work         <= '0;
      divisor_mag  <= '0;
      partial      <= '0;
      count        <= '0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      zero_case    <= 1'b0;
      ovf_case     <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      finished     <= 1'b0;
      div_zero     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work         <= dividend_mag_in;
            divisor_mag  <= divisor_mag_in;
            dividend_neg <= dividend[DIVIDEND_W-1];
            divisor_neg  <= divisor[DIVISOR_W-1];
            zero_case    <= (divisor == '0);
            ovf_case     <= (dividend == QUOT_MIN) && (divisor == '1);
            partial      <= '0;
            count        <= '0;
          end
        end
        DIVIDE: begin
          if (borrow) begin
            partial <= {partial[DIVISOR_W-1:0], work[DIVIDEND_W-1]};
          end else begin
            partial <= trial[DIVISOR_W:0];
          end
          work  <= {work[DIVIDEND_W-2:0], ~borrow};
          count <= count + 1'b1;
        end
        FIXUP: begin
          if (zero_case) begin
            quotient  <= dividend_neg ? QUOT_MIN : QUOT_MAX;
            remainder <= '0;
          end else if (ovf_case) begin
            quotient  <= QUOT_MAX;
            remainder <= '0;
          end else begin
            quotient  <= (dividend_neg ^ divisor_neg) ? -work : work;
            remainder <= dividend_neg ? -partial[DIVISOR_W-1:0] : partial[DIVISOR_W-1:0];
          end
          div_zero <= zero_case;
          overflow <= ovf_case;
          finished <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider
// Self-checking bench for sequential_divider: directed cases, handshake
// corner cases, mid-run reset and randomized operands against an
// arithmetic reference model.
module tb_sequential_divider;

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        finished;
  logic        busy;
  logic        div_zero;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  sequential_divider dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .finished  (finished),
    .busy      (busy),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Global time bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model from signed arithmetic rules.
  function automatic void ref_div(input logic signed [31:0] a, input logic signed [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
    longint la;
    longint lb;
    la = a;
    lb = b;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 16'sd0) begin
      dz = 1'b1;
      q  = (a < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      r  = 16'h0;
    end else if (a == 32'sh8000_0000 && b == -16'sd1) begin
      ov = 1'b1;
      q  = 32'h7FFF_FFFF;
      r  = 16'h0;
    end else begin
      q = 32'(la / lb);
      r = 16'(la % lb);
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for finished, counting edges since the start edge.
  task automatic wait_finished(output int cycles);
    cycles = 0;
    while (finished !== 1'b1 && cycles < 40) begin
      @(posedge sys_clk);
      #1;
      cycles++;
    end
  endtask

  // Launch one division, then check latency, pulse width and results.
  task automatic apply_stimulus(input logic [31:0] a, input logic [15:0] b, input string tag);
    logic [31:0] eq;
    logic [15:0] er;
    logic        edz;
    logic        eov;
    int          cycles;
    ref_div(a, b, eq, er, edz, eov);
    @(negedge sys_clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    check_output({tag, " busy"}, 32'(busy), 32'd1);
    wait_finished(cycles);
    check_output({tag, " latency"}, cycles, 33);
    check_output({tag, " quotient"}, quotient, eq);
    check_output({tag, " remainder"}, 32'(remainder), 32'(er));
    check_output({tag, " div_zero"}, 32'(div_zero), 32'(edz));
    check_output({tag, " overflow"}, 32'(overflow), 32'(eov));
    check_output({tag, " busy_done"}, 32'(busy), 32'd0);
    @(posedge sys_clk);
    #1;
    check_output({tag, " pulse_width"}, 32'(finished), 32'd0);
  endtask

  initial begin
    int          cycles;
    int          pulses;
    int          lat;
    logic [31:0] q_seen;
    logic [15:0] r_seen;
    logic [31:0] ra;
    logic [15:0] rb;

    sys_rst  = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check_output("reset quotient", quotient, 32'd0);
    check_output("reset remainder", 32'(remainder), 32'd0);
    check_output("reset finished", 32'(finished), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset div_zero", 32'(div_zero), 32'd0);
    check_output("reset overflow", 32'(overflow), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Directed sign combinations and special cases.
    apply_stimulus(32'd100, 16'd7, "100/7");
    check_output("100/7 q const", quotient, 32'd14);
    check_output("100/7 r const", 32'(remainder), 32'd2);
    apply_stimulus(-32'sd100, 16'd7, "-100/7");
    apply_stimulus(32'd100, -16'sd7, "100/-7");
    apply_stimulus(-32'sd100, -16'sd7, "-100/-7");
    check_output("-100/-7 q const", quotient, 32'd14);
    check_output("-100/-7 r const", 32'(remainder), 32'hFFFE);
    apply_stimulus(32'h8000_0000, 16'hFFFF, "minint/-1");
    repeat (3) @(posedge sys_clk);
    #1;
    check_output("overflow hold", 32'(overflow), 32'd1);
    check_output("quotient hold", quotient, 32'h7FFF_FFFF);
    apply_stimulus(32'h8000_0000, 16'h8000, "minint/minshort");
    check_output("minint/minshort q const", quotient, 32'd65536);
    apply_stimulus(32'd5, 16'd0, "5/0");
    apply_stimulus(-32'sd5, 16'd0, "-5/0");
    check_output("-5/0 q const", quotient, 32'h8000_0000);

    // Mid-run input change and start pulse are ignored.
    @(negedge sys_clk);
    dividend = 32'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    pulses = 0;
    lat    = 0;
    q_seen = '0;
    r_seen = '0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge sys_clk);
      #1;
      if (i == 8) begin
        dividend = 32'd77;
        divisor  = 16'd9;
        start    = 1'b1;
      end
      if (i == 9) start = 1'b0;
      if (finished === 1'b1) begin
        pulses++;
        lat    = i;
        q_seen = quotient;
        r_seen = remainder;
      end
    end
    check_output("midrun pulses", pulses, 1);
    check_output("midrun latency", lat, 33);
    check_output("midrun quotient", q_seen, 32'd333);
    check_output("midrun remainder", 32'(r_seen), 32'd1);

    // Start accepted in the finished cycle.
    @(negedge sys_clk);
    dividend = 32'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    wait_finished(cycles);
    check_output("first latency", cycles, 33);
    check_output("first quotient", quotient, 32'd333);
    dividend = 32'd1234;
    divisor  = -16'sd10;
    start    = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    wait_finished(cycles);
    check_output("back2back latency", cycles, 33);
    check_output("back2back quotient", quotient, -32'sd123);
    check_output("back2back remainder", 32'(remainder), 32'd4);

    // Reset during DIVIDE iteration 10.
    @(negedge sys_clk);
    dividend = 32'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    check_output("abort quotient", quotient, 32'd0);
    check_output("abort remainder", 32'(remainder), 32'd0);
    check_output("abort busy", 32'(busy), 32'd0);
    check_output("abort finished", 32'(finished), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge sys_clk);
      #1;
      if (finished === 1'b1) pulses++;
    end
    check_output("abort no pulse", pulses, 0);
    apply_stimulus(32'd77, 16'd5, "77/5");
    check_output("77/5 q const", quotient, 32'd15);
    check_output("77/5 r const", 32'(remainder), 32'd2);

    // Randomized operands.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom();
      case (i % 4)
        0:       rb = 16'($urandom_range(1, 20));
        1:       rb = 16'($urandom());
        2:       rb = -16'($urandom_range(1, 300));
        default: rb = 16'($urandom());
      endcase
      if (i == 7) rb = 16'd0;
      if (i == 11) ra = 32'h8000_0000;
      apply_stimulus(ra, rb, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Sequential 32 ÷ 16 signed divider using restoring shift-subtract, one quotient bit per clock. It is the inverse counterpart of the arithmetic unit's sequential multiplier and sits beside it, sharing the same start/finished handshake. It serves the encode path, where residuals are divided by the dequantisation scale factor. Operands are captured at `start`, so callers may change inputs while a division is in flight.

## Interface
- `DIVIDEND_W`, default 32: dividend and quotient width.
- `DIVISOR_W`, default 16: divisor and remainder width.
- `sys_clk`  in  1  single clock; all state changes on its rising edge.
- `sys_rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request a division; sampled only in IDLE.
- `dividend`  in  32  signed dividend.
- `divisor`  in  16  signed divisor.
- `quotient`  out  32  signed quotient, truncated toward zero.
- `remainder`  out  16  signed remainder; sign follows the dividend.
- `finished`  out  1  one-cycle pulse when `quotient`/`remainder` are updated.
- `busy`  out  1  high in every state except IDLE.
- `div_zero`  out  1  flag for the last result: divisor was 0.
- `overflow`  out  1  flag for the last result: -2^31 ÷ -1.

## Operation
- States: IDLE, DIVIDE, FIXUP.
- **IDLE, `start`=1:**
  - latch `|dividend|` as 32-bit unsigned, `|divisor|` as 16-bit unsigned.
  - latch the two operand sign bits.
  - set the special-case flags: divisor==0; dividend==0x80000000 with divisor==0xFFFF.
  - clear the 17-bit partial remainder; count=0; go to DIVIDE.
- **DIVIDE, each cycle:**
  - shift the dividend MSB into the partial remainder.
  - trial = partial − |divisor|.
  - if trial is non-negative, keep it and shift 1 into the quotient; otherwise shift 0.
  - count+1; after the 32nd iteration go to FIXUP.
- **FIXUP, magnitude results:**
  - negate the quotient if the operand signs differ.
  - negate the remainder if the dividend is negative.
- **FIXUP, special cases override:**
  - div_zero: quotient = 0x7FFFFFFF if dividend ≥ 0, else 0x80000000; remainder = 0.
  - overflow: quotient = 0x7FFFFFFF, remainder = 0.
- **FIXUP, outputs:** register `quotient`, `remainder`, `div_zero`, `overflow`; pulse `finished`; return to IDLE.
- Outputs hold their values until the next FIXUP.
- Internal magnitudes are unsigned; only the final outputs are signed. The remainder magnitude is at most 32767, so it always fits in 16 bits.

## Timing
- Reset values: `quotient`=0, `remainder`=0, `finished`=0, `busy`=0, `div_zero`=0, `overflow`=0; state IDLE; internal registers 0.
- Fixed latency, including the special cases:
  - `start` sampled at edge E; DIVIDE runs edges E+1..E+32; FIXUP at E+33.
  - `finished` is high for exactly the cycle after edge E+33.
  - `busy` rises after E and falls after E+33.
- `start` while `busy` is ignored: no queueing, no effect on the running division.
- `start` held high continuously launches a new division on each return to IDLE. The cycle `finished` is high is an IDLE cycle, so a `start` there is accepted.
- Asserting `sys_rst` mid-operation aborts at once:
  - all outputs go to reset values and state to IDLE.
  - no `finished` pulse is emitted for the aborted operation.
- Changes on `dividend`/`divisor` after the start edge have no effect on the result.

## Structure
- Shared package `qoa_arith_pkg` holds:
  - the state enum (IDLE/DIVIDE/FIXUP);
  - width constants 32/16;
  - saturation constants 0x7FFFFFFF and 0x80000000.
  The multiplier reuses the same widths.
- No sub-module: the datapath is one counter, one 17-bit subtractor and two shift registers. Magnitude and negation logic stays inline.

## Test plan
- 100 ÷ 7 → `quotient`=14, `remainder`=2, flags 0; `finished` exactly 33 cycles after the start edge, width 1.
- −100 ÷ 7 → −14, −2. 100 ÷ −7 → −14, 2. −100 ÷ −7 → 14, −2.
- 0x80000000 ÷ −1 → 0x7FFFFFFF, remainder 0, `overflow`=1. 0x80000000 ÷ 0x8000 → 65536, remainder 0.
- 5 ÷ 0 → 0x7FFFFFFF, `div_zero`=1. −5 ÷ 0 → 0x80000000, `div_zero`=1. Latency unchanged in both cases.
- Start 1000 ÷ 3, then:
  - change inputs and pulse `start` mid-run → result still 333 rem 1; only one `finished` pulse.
  - `start` on the `finished` cycle → second result follows 33 cycles later.
- Assert `sys_rst` at DIVIDE iteration 10 → outputs 0 and `busy` 0 immediately, no `finished`; the next division 77 ÷ 5 gives 15 rem 2.
